mem_arbiter: RTL
================

# mem_arbiter

Shares the processor's single 16-bit memory port between the instruction-fetch requester and the load/store data requester. Fetch is the fetch-stage PC read; data is LD/ST execute. The block grants one requester at a time and latches its address and write data. It drives the memory enable and read/write strobes for a fixed number of wait cycles, then returns read data with a one-cycle valid pulse. It sits between the control unit / FDE sequencer and the memory block, and replaces direct control-unit drive of mem_en and read_write.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_CYCLES, 1, extra memory cycles per access beyond the first (0 legal)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant to fetch
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched word, held until next fetch completes
- d_req  in  1  data request; held until d_gnt
- d_rw  in  1  1 = read (LD), 0 = write (ST)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant to data
- d_valid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  DATA_W  loaded word, held until next data read completes
- mem_en  out  1  memory enable
- mem_rw  out  1  1 = read, 0 = write
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, valid on last ACCESS cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: on a rising edge with any request high, latch the owner, address, rw and wdata. Pulse the owner's gnt for that cycle and go to ACCESS. Fetch accesses are always reads.
- Arbitration when both requests are high: data wins (fixed priority), unless modified under Configuration.
- ACCESS: mem_en=1, mem_rw and mem_addr from the latch. The wait counter loads WAIT_CYCLES on entry and decrements each cycle. At counter==0, a read captures mem_rdata into the owner's rdata register, and the state goes to DONE.
- DONE: pulse the owner's valid for one cycle, then go to IDLE. A request is not sampled in DONE.
- A request that drops before its grant is ignored. Inputs are not resampled after the grant.
- Reset values: if_gnt=d_gnt=if_valid=d_valid=0, mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0, if_rdata=d_rdata=0, busy=0, state=IDLE.
- Reset asserted mid-access: abort immediately to reset values. No valid pulse follows.

## Timing
- Request high at edge N in IDLE: gnt high during cycle N..N+1 and mem_en high from N for WAIT_CYCLES+1 cycles.
- Valid pulses in the following cycle.
- Request-to-valid latency is WAIT_CYCLES+2 cycles. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles, because IDLE costs one cycle.
- mem_addr, mem_rw and mem_wdata are stable for the entire ACCESS window.
- mem_rw returns to 1 and mem_en to 0 in DONE and IDLE.
- Counter width is max(1, clog2(WAIT_CYCLES+1)). There is no wrap: the counter is reloaded only on ACCESS entry.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A last_owner flop is updated on each grant. On a simultaneous request, the requester that was not last granted wins. last_owner resets to data, so fetch wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority with data over fetch. The last_owner flop is absent.

## Structure
- Shared package cpu_pkg holds:
  - state encodings ARB_IDLE/ARB_ACCESS/ARB_DONE
  - MEM_READ=1'b1 and MEM_WRITE=1'b0, matching control-unit read_write polarity
  - owner encodings OWN_IF/OWN_D
- One sub-module, wait_counter: loadable down-counter with a zero flag, parameterized by width.

## Test plan
- Fetch-only read, WAIT_CYCLES=1, if_addr=0x0010, mem_rdata=0xA55A:
  - if_gnt on cycle 0, mem_en high for cycles 0–1, if_valid at cycle 2, if_rdata=0xA55A.
- Data store, d_rw=0, d_addr=0x0100, d_wdata=0x1234:
  - mem_rw=0 and mem_wdata=0x1234 for 2 cycles.
  - d_valid pulses once; d_rdata is unchanged.
- Simultaneous if_req and d_req (d_rw=1) without the macro:
  - d_gnt first; if_gnt 4 cycles later, after DONE and IDLE.
- Same stimulus with MEM_ARB_RR_EN and three consecutive ties:
  - grants in the order fetch, data, fetch.
- reset low during ACCESS of a load:
  - mem_en=0, mem_rw=1 and busy=0 immediately.
  - No d_valid after reset releases.
- WAIT_CYCLES=0 read:
  - mem_en for exactly 1 cycle, valid 1 cycle later, latency 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: memory arbiter states, read/write strobe polarity and
// owner codes, plus the wait-counter width rule.
package cpu_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_DONE   = 2'd2;

  // Same polarity as the control unit's read_write line.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Loadable down-counter with a zero flag; times the ACCESS window of the
// memory arbiter. It stops at zero and is only refilled by a load.
module wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise data has fixed priority.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W     = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0] state;
  logic       owner;
  logic       lat_rw;
  logic       take;
  logic       pick_d;
  logic       cnt_zero;

  assign take = (state == ARB_IDLE) && (if_req || d_req);

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick_d = d_req;
    if (if_req && d_req) begin
      pick_d = (last_owner == OWN_IF);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_D;
    end else if (take) begin
      last_owner <= pick_d ? OWN_D : OWN_IF;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      lat_rw    <= MEM_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (take) begin
            state <= ARB_ACCESS;
            if (pick_d) begin
              owner     <= OWN_D;
              lat_rw    <= d_rw;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              d_gnt     <= 1'b1;
            end else begin
              owner    <= OWN_IF;
              lat_rw   <= MEM_READ;
              mem_addr <= if_addr;
              if_gnt   <= 1'b1;
            end
          end
        end
        // Memory data is only trusted on the final cycle of the window.
        ARB_ACCESS: begin
          if (cnt_zero) begin
            state <= ARB_DONE;
            if (lat_rw == MEM_READ) begin
              if (owner == OWN_D) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (take),
    .load_val (WAIT_LOAD),
    .dec      (state == ARB_ACCESS),
    .zero     (cnt_zero)
  );

  assign mem_en   = (state == ARB_ACCESS);
  assign mem_rw   = mem_en ? lat_rw : MEM_READ;
  assign if_valid = (state == ARB_DONE) && (owner == OWN_IF);
  assign d_valid  = (state == ARB_DONE) && (owner == OWN_D);
  assign busy     = (state != ARB_IDLE);

endmodule
